// File: rtl/plab3_mem_ns_pkg.sv
// Shared encodings for the NS-bit memory guard: FSM states, domain values and
// field widths of the cacheline memory messages.
package plab3_mem_ns_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFwd  = 3'd1,
    StWait = 3'd2,
    StDeny = 3'd3,
    StResp = 3'd4
  } state_e;

  localparam logic DOM_SEC = 1'b0;
  localparam logic DOM_NS  = 1'b1;

  localparam int unsigned ViolCountNbits = 16;

  // Message layout, MSB first. Request: type | opaque | addr | len | data.
  // Response: type | opaque | test | len | data.
  localparam int unsigned MemTypeNbits = 3;
  localparam int unsigned MemTestNbits = 2;

endpackage

// File: rtl/plab3_mem_ns_region_check.sv
// Combinational secure-region test: denies non-secure accesses that fall inside
// [p_sec_base, p_sec_limit).
module plab3_mem_ns_region_check
  import plab3_mem_ns_pkg::*;
#(
  parameter int unsigned    abw         = 32,
  parameter logic [abw-1:0] p_sec_base  = 32'h0000_0000,
  parameter logic [abw-1:0] p_sec_limit = 32'h0000_1000
) (
  input  logic [abw-1:0] addr,
  input  logic           domain,
  output logic           deny
);

  // base <= addr < limit folded into one unsigned compare on the modular offset
  localparam logic [abw-1:0] Span = p_sec_limit - p_sec_base;

  logic [abw-1:0] offset;
  logic           hit;

  assign offset = addr - p_sec_base;
  assign hit    = offset < Span;
  assign deny   = hit && (domain == DOM_NS);

endmodule

// File: rtl/plab3_mem_ns_mem_guard.sv
// NS-bit guard between the blocking cache refill/evict port and main memory.
// One transaction in flight; denied requests are answered locally with zero data.
module plab3_mem_ns_mem_guard
  import plab3_mem_ns_pkg::*;
#(
  parameter int unsigned    p_opaque_nbits = 8,
  parameter int unsigned    abw            = 32,
  parameter int unsigned    clw            = 128,
  parameter logic [abw-1:0] p_sec_base     = 32'h0000_0000,
  parameter logic [abw-1:0] p_sec_limit    = 32'h0000_1000
) (
  input  logic clk,
  input  logic reset,

  input  logic memreq_val,
  output logic memreq_rdy,
  input  logic memreq_domain,
  input  logic [MemTypeNbits+p_opaque_nbits+abw+$clog2(clw/8)+clw-1:0] memreq_msg,

  output logic memresp_val,
  input  logic memresp_rdy,
  output logic memresp_domain,
  output logic [MemTypeNbits+p_opaque_nbits+MemTestNbits+$clog2(clw/8)+clw-1:0] memresp_msg,

  output logic mem_memreq_val,
  input  logic mem_memreq_rdy,
  output logic [MemTypeNbits+p_opaque_nbits+abw+$clog2(clw/8)+clw-1:0] mem_memreq_msg,

  input  logic mem_memresp_val,
  output logic mem_memresp_rdy,
  input  logic [MemTypeNbits+p_opaque_nbits+MemTestNbits+$clog2(clw/8)+clw-1:0] mem_memresp_msg,

  output logic                      violation,
  output logic [ViolCountNbits-1:0] violation_count
);

  localparam int unsigned LenNbits  = $clog2(clw / 8);
  localparam int unsigned ReqNbits  = MemTypeNbits + p_opaque_nbits + abw + LenNbits + clw;
  localparam int unsigned RespNbits = MemTypeNbits + p_opaque_nbits + MemTestNbits + LenNbits
                                      + clw;

  state_e                    state_q, state_d;
  logic [ReqNbits-1:0]       req_q;
  logic                      dom_q;
  logic [RespNbits-1:0]      resp_q, resp_d;
  logic [ViolCountNbits-1:0] count_q, count_d;
  logic                      req_en, resp_en;
  logic                      deny;

  logic [abw-1:0]            in_addr;
  logic [MemTypeNbits-1:0]   lat_type;
  logic [p_opaque_nbits-1:0] lat_opaque;
  logic [RespNbits-1:0]      deny_resp;

  assign in_addr    = memreq_msg[LenNbits+clw +: abw];
  assign lat_type   = req_q[ReqNbits-1 -: MemTypeNbits];
  assign lat_opaque = req_q[ReqNbits-MemTypeNbits-1 -: p_opaque_nbits];
  // Denied reads and dropped writes both answer with test=0, len=0, data=0
  assign deny_resp  = {lat_type, lat_opaque, {(MemTestNbits + LenNbits + clw){1'b0}}};

  // The decision is taken on the cycle the request is latched
  plab3_mem_ns_region_check #(
    .abw         (abw),
    .p_sec_base  (p_sec_base),
    .p_sec_limit (p_sec_limit)
  ) u_region_check (
    .addr   (in_addr),
    .domain (memreq_domain),
    .deny   (deny)
  );

  always_comb begin
    state_d         = state_q;
    memreq_rdy      = 1'b0;
    mem_memreq_val  = 1'b0;
    mem_memresp_rdy = 1'b0;
    memresp_val     = 1'b0;
    violation       = 1'b0;
    req_en          = 1'b0;
    resp_en         = 1'b0;
    resp_d          = mem_memresp_msg;
    count_d         = count_q;
    unique case (state_q)
      StIdle: begin
        memreq_rdy = 1'b1;
        if (memreq_val) begin
          req_en  = 1'b1;
          state_d = deny ? StDeny : StFwd;
        end
      end
      StFwd: begin
        mem_memreq_val = 1'b1;
        if (mem_memreq_rdy) state_d = StWait;
      end
      StWait: begin
        mem_memresp_rdy = 1'b1;
        if (mem_memresp_val) begin
          resp_en = 1'b1;
          state_d = StResp;
        end
      end
      StDeny: begin
        violation = 1'b1;
        resp_en   = 1'b1;
        resp_d    = deny_resp;
        if (count_q != '1) count_d = count_q + ViolCountNbits'(1);
        state_d   = StResp;
      end
      StResp: begin
        memresp_val = 1'b1;
        if (memresp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      dom_q   <= DOM_SEC;
      resp_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (req_en) begin
        req_q <= memreq_msg;
        dom_q <= memreq_domain;
      end
      if (resp_en) resp_q <= resp_d;
    end
  end

  assign mem_memreq_msg  = req_q;
  assign memresp_msg     = resp_q;
  assign memresp_domain  = dom_q;
  assign violation_count = count_q;

endmodule

// File: tb/tb_plab3_mem_ns_mem_guard.sv
// Bench for the NS-bit memory guard: directed scenarios plus random traffic checked
// against a region/domain model and a sparse memory model played by the bench.
module tb_plab3_mem_ns_mem_guard;

  localparam int unsigned O     = 8;
  localparam int unsigned ABW   = 32;
  localparam int unsigned CLW   = 128;
  localparam int unsigned LENW  = 4;
  localparam int unsigned REQW  = 3 + O + ABW + LENW + CLW;
  localparam int unsigned RESPW = 3 + O + 2 + LENW + CLW;
  localparam logic [31:0] SEC_BASE  = 32'h0000_0000;
  localparam logic [31:0] SEC_LIMIT = 32'h0000_1000;
  localparam logic [2:0]  RD = 3'd0;
  localparam logic [2:0]  WR = 3'd1;

  logic             clk;
  logic             reset;
  logic             memreq_val, memreq_rdy, memreq_domain;
  logic [REQW-1:0]  memreq_msg;
  logic             memresp_val, memresp_rdy, memresp_domain;
  logic [RESPW-1:0] memresp_msg;
  logic             mem_memreq_val, mem_memreq_rdy;
  logic [REQW-1:0]  mem_memreq_msg;
  logic             mem_memresp_val, mem_memresp_rdy;
  logic [RESPW-1:0] mem_memresp_msg;
  logic             violation;
  logic [15:0]      violation_count;

  plab3_mem_ns_mem_guard #(
    .p_opaque_nbits (O),
    .abw            (ABW),
    .clw            (CLW),
    .p_sec_base     (SEC_BASE),
    .p_sec_limit    (SEC_LIMIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .memreq_val      (memreq_val),
    .memreq_rdy      (memreq_rdy),
    .memreq_domain   (memreq_domain),
    .memreq_msg      (memreq_msg),
    .memresp_val     (memresp_val),
    .memresp_rdy     (memresp_rdy),
    .memresp_domain  (memresp_domain),
    .memresp_msg     (memresp_msg),
    .mem_memreq_val  (mem_memreq_val),
    .mem_memreq_rdy  (mem_memreq_rdy),
    .mem_memreq_msg  (mem_memreq_msg),
    .mem_memresp_val (mem_memresp_val),
    .mem_memresp_rdy (mem_memresp_rdy),
    .mem_memresp_msg (mem_memresp_msg),
    .violation       (violation),
    .violation_count (violation_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_cnt = '0;
  logic [127:0] mem [logic [31:0]];

  // Handshake monitors, counted on the active edge
  int n_mreq = 0, n_mresp = 0, n_resp = 0, n_viol = 0;
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_memreq_val && mem_memreq_rdy)   n_mreq  <= n_mreq + 1;
      if (mem_memresp_val && mem_memresp_rdy) n_mresp <= n_mresp + 1;
      if (memresp_val && memresp_rdy)         n_resp  <= n_resp + 1;
      if (violation)                          n_viol  <= n_viol + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_deny(input logic [31:0] addr, input bit dom);
    longint a;
    a = longint'(addr);
    return dom && (a >= longint'(SEC_BASE)) && (a < longint'(SEC_LIMIT));
  endfunction

  function automatic logic [127:0] mem_read(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return {addr, ~addr, addr ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
  endfunction

  task automatic txn(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                     input logic [127:0] data, input bit dom, input int mstall,
                     input int mdelay, input int rstall, input bit abort);
    logic [REQW-1:0]  req;
    logic [RESPW-1:0] mresp, exp_resp;
    logic [127:0]     rdata;
    logic [3:0]       len;
    bit               dn;
    int               b_mreq, b_mresp, b_resp, b_viol;
    len      = 4'($urandom);
    req      = {typ, opq, addr, len, data};
    dn       = model_deny(addr, dom);
    exp_resp = '0;
    b_mreq = n_mreq; b_mresp = n_mresp; b_resp = n_resp; b_viol = n_viol;
    memreq_val = 1'b1; memreq_msg = req; memreq_domain = dom;
    check_eq("idle_req_rdy", memreq_rdy, 1);
    @(posedge clk); @(negedge clk);
    memreq_val    = 1'b0;
    memreq_msg    = REQW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom()});
    memreq_domain = 1'($urandom);
    if (dn) begin
      model_cnt = (model_cnt == 16'hFFFF) ? model_cnt : model_cnt + 16'd1;
      exp_resp  = {typ, opq, 2'b00, 4'h0, 128'h0};
      check_eq("deny_viol_n1", violation, 1);
      check_eq("deny_no_fwd", mem_memreq_val, 0);
      check_eq("deny_no_resp_n1", memresp_val, 0);
      @(posedge clk); @(negedge clk);
      check_eq("deny_viol_n2", violation, 0);
    end else begin
      check_eq("fwd_val", mem_memreq_val, 1);
      check_eq("fwd_msg", mem_memreq_msg, req);
      check_eq("fwd_no_viol", violation, 0);
      for (int i = 0; i < mstall; i++) begin
        mem_memresp_val = 1'b1;
        mem_memresp_msg = RESPW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        check_eq("fwd_stray_rdy", mem_memresp_rdy, 0);
        @(posedge clk); @(negedge clk);
        check_eq("fwd_hold_val", mem_memreq_val, 1);
        check_eq("fwd_hold_msg", mem_memreq_msg, req);
        check_eq("fwd_busy", memreq_rdy, 0);
      end
      mem_memresp_val = 1'b0;
      mem_memreq_rdy  = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_memreq_rdy = 1'b0;
      check_eq("wait_rdy", mem_memresp_rdy, 1);
      check_eq("wait_no_fwd", mem_memreq_val, 0);
      if (typ == WR) begin
        mem[addr] = data;
        rdata     = '0;
      end else begin
        rdata = mem_read(addr);
      end
      mresp    = {typ, opq, 2'b00, 4'($urandom), rdata};
      exp_resp = mresp;
      if (abort) begin
        reset = 1'b1;
        #1;
        check_eq("abort_req_rdy", memreq_rdy, 1);
        check_eq("abort_cnt", violation_count, 0);
        check_eq("abort_wait_rdy", mem_memresp_rdy, 0);
        model_cnt = '0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        return;
      end
      for (int j = 0; j < mdelay; j++) begin
        @(posedge clk); @(negedge clk);
        check_eq("wait_hold", memresp_val, 0);
      end
      mem_memresp_val = 1'b1;
      mem_memresp_msg = mresp;
      @(posedge clk); @(negedge clk);
      mem_memresp_val = 1'b0;
      mem_memresp_msg = RESPW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
    check_eq("resp_val", memresp_val, 1);
    check_eq("resp_msg", memresp_msg, exp_resp);
    check_eq("resp_dom", memresp_domain, dom);
    check_eq("resp_cnt", violation_count, model_cnt);
    check_eq("resp_busy", memreq_rdy, 0);
    for (int k = 0; k < rstall; k++) begin
      @(posedge clk); @(negedge clk);
      check_eq("resp_hold_val", memresp_val, 1);
      check_eq("resp_hold_msg", memresp_msg, exp_resp);
      check_eq("resp_hold_busy", memreq_rdy, 0);
    end
    memresp_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    memresp_rdy = 1'b0;
    check_eq("done_idle", memreq_rdy, 1);
    check_eq("done_no_val", memresp_val, 0);
    check_eq("xfer_mreq", n_mreq - b_mreq, dn ? 0 : 1);
    check_eq("xfer_mresp", n_mresp - b_mresp, dn ? 0 : 1);
    check_eq("xfer_resp", n_resp - b_resp, 1);
    check_eq("viol_pulses", n_viol - b_viol, dn ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          sel;
    reset = 1'b1;
    memreq_val = 1'b0; memreq_domain = 1'b0; memreq_msg = '0; memresp_rdy = 1'b0;
    mem_memreq_rdy = 1'b0; mem_memresp_val = 1'b0; mem_memresp_msg = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_rdy", memreq_rdy, 1);
    check_eq("rst_resp_val", memresp_val, 0);
    check_eq("rst_fwd_val", mem_memreq_val, 0);
    check_eq("rst_mresp_rdy", mem_memresp_rdy, 0);
    check_eq("rst_viol", violation, 0);
    check_eq("rst_cnt", violation_count, 0);
    check_eq("rst_resp_msg", memresp_msg, 0);
    reset = 1'b0;
    @(negedge clk);

    mem[32'h0000_2000] = {4{32'hDEAD_BEEF}};
    txn(RD, 8'h11, 32'h0000_2000, 128'h0, 1'b1, 0, 1, 0, 1'b0);
    txn(RD, 8'h22, 32'h0000_0FF0, 128'h1234, 1'b1, 0, 0, 0, 1'b0);
    txn(WR, 8'h33, 32'h0000_0100, {4{32'hCAFE_F00D}}, 1'b0, 1, 0, 0, 1'b0);
    txn(WR, 8'h34, 32'h0000_0100, {4{32'hBAD0_BAD0}}, 1'b1, 0, 0, 1, 1'b0);
    txn(RD, 8'h35, 32'h0000_0100, 128'h0, 1'b0, 0, 2, 0, 1'b0);
    // Region edges
    txn(RD, 8'h40, 32'h0000_0000, 128'h0, 1'b1, 0, 0, 0, 1'b0);
    txn(RD, 8'h41, SEC_LIMIT - 32'd16, 128'h0, 1'b1, 0, 0, 0, 1'b0);
    txn(RD, 8'h42, SEC_LIMIT, 128'h0, 1'b1, 0, 0, 0, 1'b0);
    txn(RD, 8'h43, 32'hFFFF_FFF0, 128'h0, 1'b1, 0, 0, 0, 1'b0);
    txn(RD, 8'h44, 32'h0000_0800, 128'h0, 1'b0, 0, 0, 0, 1'b0);
    // Back-pressure on both sides
    txn(RD, 8'h50, 32'h0000_3000, 128'h0, 1'b0, 5, 0, 3, 1'b0);
    // Reset while waiting on memory, then a normal transaction
    txn(RD, 8'h60, 32'h0000_4000, 128'h0, 1'b1, 1, 0, 0, 1'b1);
    txn(RD, 8'h61, 32'h0000_4000, 128'h0, 1'b1, 0, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = {20'h0, 8'($urandom), 4'h0};
        1:       a = SEC_LIMIT + {20'h0, 8'($urandom), 4'h0};
        2:       a = ($urandom_range(0, 1) == 0) ? SEC_LIMIT - 32'd16 : SEC_LIMIT;
        default: a = $urandom & 32'hFFFF_FFF0;
      endcase
      txn(3'($urandom_range(0, 1)), 8'($urandom), a,
          {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Preload the counter near its ceiling
    force dut.count_q = 16'hFFFE;
    @(posedge clk); @(negedge clk);
    release dut.count_q;
    model_cnt = 16'hFFFE;
    check_eq("preload_cnt", violation_count, 16'hFFFE);
    for (int s = 0; s < 3; s++) begin
      txn(RD, 8'h70 + 8'(s), 32'h0000_0200, 128'h0, 1'b1, 0, 0, 0, 1'b0);
    end
    check_eq("sat_cnt", violation_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
